// File: rtl/sorter_issue_ctrl.sv
// Round-robin issue controller sharing one fixed-latency 4-input sorter among NUM_REQ requesters.
// Credit admission (inflight + buffered < depth) keeps the result FIFO from overflowing.
module sorter_issue_ctrl #(
  parameter int DATAWIDTH  = 8,
  parameter int NUM_REQ    = 2,
  parameter int PIPE_LAT   = 3,
  parameter int FIFO_DEPTH = 8,
  parameter int TAGW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  input  logic [NUM_REQ*4*DATAWIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  output logic                           sort_valid_o,
  output logic [TAGW-1:0]                sort_tag_o,
  output logic [4*DATAWIDTH-1:0]         sort_data_o,
  input  logic                           sort_valid_i,
  input  logic [TAGW-1:0]                sort_tag_i,
  input  logic [4*DATAWIDTH-1:0]         sort_data_i,
  output logic                           out_valid_o,
  output logic [TAGW-1:0]                out_tag_o,
  output logic [4*DATAWIDTH-1:0]         out_data_o,
  input  logic                           out_ready_i,
  output logic                           err_o
);

  localparam int VW = 4 * DATAWIDTH;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  if (NUM_REQ < 2 || FIFO_DEPTH < 1 || PIPE_LAT < 1) begin : g_bad_params
    $error("sorter_issue_ctrl: unsupported parameter set");
  end

  logic [TAGW-1:0]    ptr, gidx, ptr_next, idx;
  logic               found, credit_ok, accept, ret_ok, wr_en, rd_en, full;
  logic [NUM_REQ-1:0] grant;
  logic [CW-1:0]      inflight, count, count_next;
  logic [CW:0]        used;
  logic [PW-1:0]      wr_ptr, rd_ptr, rd_next;
  logic [VW-1:0]      mem_data [FIFO_DEPTH];
  logic [TAGW-1:0]    mem_tag  [FIFO_DEPTH];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] v);
    return (v == PW'(FIFO_DEPTH - 1)) ? '0 : v + 1'b1;
  endfunction

  // Conservative: a pop in this cycle only frees its credit next cycle.
  assign used      = {1'b0, inflight} + {1'b0, count};
  assign credit_ok = used < (CW + 1)'(FIFO_DEPTH);

  always_comb begin
    grant = '0;
    gidx  = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = TAGW'((int'(ptr) + k) % NUM_REQ);
      if (!found && req_valid_i[idx]) begin
        found = 1'b1;
        gidx  = idx;
      end
    end
    if (found) grant[gidx] = 1'b1;
  end

  assign req_ready_o = grant & {NUM_REQ{credit_ok && !rst_i}};
  assign accept      = found && credit_ok && !rst_i;
  assign ptr_next    = (int'(gidx) == NUM_REQ - 1) ? '0 : gidx + 1'b1;

  assign ret_ok      = sort_valid_i && (inflight != '0);
  assign full        = (count == CW'(FIFO_DEPTH));
  assign wr_en       = sort_valid_i && !full;
  assign out_valid_o = (count != '0);
  assign rd_en       = out_valid_o && out_ready_i;
  assign rd_next     = rd_en ? ptr_inc(rd_ptr) : rd_ptr;

  always_comb begin
    count_next = count;
    case ({wr_en, rd_en})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_data[wr_ptr] <= sort_data_i;
      mem_tag[wr_ptr]  <= sort_tag_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr          <= '0;
      sort_valid_o <= 1'b0;
      sort_tag_o   <= '0;
      sort_data_o  <= '0;
      inflight     <= '0;
      count        <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      out_tag_o    <= '0;
      out_data_o   <= '0;
      err_o        <= 1'b0;
    end else begin
      sort_valid_o <= accept;
      if (accept) begin
        sort_tag_o  <= gidx;
        sort_data_o <= req_data_i[int'(gidx)*VW +: VW];
        ptr         <= ptr_next;
      end

      case ({accept, ret_ok})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
      if (sort_valid_i && inflight == '0) err_o <= 1'b1;

      if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
      rd_ptr <= rd_next;
      count  <= count_next;

      // Head register: bypass the incoming result when it lands in the head slot.
      if (count_next != '0) begin
        if (wr_en && wr_ptr == rd_next) begin
          out_tag_o  <= sort_tag_i;
          out_data_o <= sort_data_i;
        end else begin
          out_tag_o  <= mem_tag[rd_next];
          out_data_o <= mem_data[rd_next];
        end
      end
    end
  end

endmodule

// File: tb/tb_sorter_issue_ctrl.sv
// Bench for sorter_issue_ctrl: behavioural sorter plus queue-based reference model.
module tb_sorter_issue_ctrl;
  localparam int DW = 8, NR = 2, PL = 3, FD = 8, TW = 1, VW = 4 * DW;

  logic              clk_i = 1'b0, rst_i = 1'b1;
  logic [NR-1:0]     req_valid_i = '0, req_ready_o;
  logic [NR*VW-1:0]  req_data_i = '0;
  logic              sort_valid_o, sort_valid_i, out_valid_o, out_ready_i = 1'b0, err_o;
  logic [TW-1:0]     sort_tag_o, sort_tag_i, out_tag_o;
  logic [VW-1:0]     sort_data_o, sort_data_i, out_data_o;

  sorter_issue_ctrl #(.DATAWIDTH(DW), .NUM_REQ(NR), .PIPE_LAT(PL), .FIFO_DEPTH(FD)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_data_i(req_data_i),
    .req_ready_o(req_ready_o), .sort_valid_o(sort_valid_o), .sort_tag_o(sort_tag_o),
    .sort_data_o(sort_data_o), .sort_valid_i(sort_valid_i), .sort_tag_i(sort_tag_i),
    .sort_data_i(sort_data_i), .out_valid_o(out_valid_o), .out_tag_o(out_tag_o),
    .out_data_o(out_data_o), .out_ready_i(out_ready_i), .err_o(err_o));

  always #5 clk_i = ~clk_i;

  function automatic logic [VW-1:0] sort4(input logic [VW-1:0] v);
    logic [DW-1:0] e [4];
    logic [DW-1:0] t;
    for (int i = 0; i < 4; i++) e[i] = v[i*DW +: DW];
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3 - i; j++)
        if (e[j] > e[j+1]) begin t = e[j]; e[j] = e[j+1]; e[j+1] = t; end
    return {e[3], e[2], e[1], e[0]};
  endfunction

  // Behavioural sorter: PL-cycle pipe, ascending order, element 0 in the LSBs.
  logic [PL-1:0] sr_v;
  logic [TW-1:0] sr_t [PL];
  logic [VW-1:0] sr_d [PL];
  logic          inj = 1'b0;
  logic [VW-1:0] inj_data = '0;

  always @(posedge clk_i) begin
    if (rst_i) sr_v <= '0;
    else begin
      sr_v    <= {sr_v[PL-2:0], sort_valid_o};
      sr_t[0] <= sort_tag_o;
      sr_d[0] <= sort4(sort_data_o);
      for (int i = 1; i < PL; i++) begin
        sr_t[i] <= sr_t[i-1];
        sr_d[i] <= sr_d[i-1];
      end
    end
  end

  assign sort_valid_i = sr_v[PL-1] | inj;
  assign sort_tag_i   = inj ? 1'b1 : sr_t[PL-1];
  assign sort_data_i  = inj ? inj_data : sr_d[PL-1];

  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model state
  int                 mp = 0, m_infl = 0, acc_cnt = 0;
  logic               m_err = 1'b0, m_sv = 1'b0, zero_chk = 1'b0;
  logic [TW-1:0]      m_tag = '0;
  logic [VW-1:0]      m_data = '0;
  logic [TW+VW-1:0]   mq [$];
  logic [NR-1:0]      last_ready;

  task automatic step(input logic [NR-1:0] v, input logic [NR*VW-1:0] d,
                      input logic ordy, input logic rst);
    logic [NR-1:0]    eg;
    logic [TW+VW-1:0] head, rdat;
    logic             ret, pop, qfull;
    int               g;
    rst_i = rst; req_valid_i = v; req_data_i = d; out_ready_i = ordy;
    @(negedge clk_i);
    eg = '0;
    g  = -1;
    if (!rst && (m_infl + mq.size() < FD))
      for (int k = 0; k < NR; k++)
        if (g < 0 && v[(mp + k) % NR]) g = (mp + k) % NR;
    if (g >= 0) eg[g] = 1'b1;
    last_ready = req_ready_o;
    check("req_ready", req_ready_o, eg);
    check("sort_valid", sort_valid_o, m_sv);
    check("sort_tag", sort_tag_o, m_tag);
    check("sort_data", sort_data_o, m_data);
    check("out_valid", out_valid_o, mq.size() != 0);
    check("err", err_o, m_err);
    if (mq.size() != 0) begin
      head = mq[0];
      check("out_tag", out_tag_o, head[TW+VW-1:VW]);
      check("out_data", out_data_o, head[VW-1:0]);
    end else if (zero_chk) begin
      check("out_tag_zero", out_tag_o, 0);
      check("out_data_zero", out_data_o, 0);
    end
    ret  = sort_valid_i;
    rdat = {sort_tag_i, sort_data_i};
    pop  = (mq.size() != 0) && ordy;
    @(posedge clk_i);
    if (rst) begin
      mp = 0; m_infl = 0; m_err = 1'b0; m_sv = 1'b0; m_tag = '0; m_data = '0;
      mq.delete();
    end else begin
      m_sv = (g >= 0);
      if (g >= 0) begin
        m_tag  = TW'(g);
        m_data = d[g*VW +: VW];
        mp     = (g + 1) % NR;
        acc_cnt++;
      end
      qfull = (mq.size() == FD);
      if (pop) void'(mq.pop_front());
      if (ret && !qfull) mq.push_back(rdat);
      if (ret && m_infl == 0) m_err = 1'b1;
      m_infl = m_infl + ((g >= 0) ? 1 : 0) - ((ret && m_infl > 0) ? 1 : 0);
    end
    #1;
  endtask

  function automatic logic [NR*VW-1:0] rnd_data();
    return {$urandom, $urandom};
  endfunction

  task automatic do_reset();
    step('1, rnd_data(), 1'b0, 1'b1);
    step('1, rnd_data(), 1'b0, 1'b1);
  endtask

  initial begin
    @(posedge clk_i); #1;
    // Reset with all requesters valid; first grant must go to requester 0.
    zero_chk = 1'b1;
    do_reset();
    step('1, rnd_data(), 1'b1, 1'b0);
    zero_chk = 1'b0;
    check("first_grant", last_ready, 2'b01);

    // Single issue from requester 1 with {4,1,3,2}.
    do_reset();
    step(2'b10, {8'd2, 8'd3, 8'd1, 8'd4, 32'h0}, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step('0, rnd_data(), 1'b1, 1'b0);

    // Back-pressure: exactly FD accepts, then one more per pop.
    do_reset();
    acc_cnt = 0;
    for (int i = 0; i < 20; i++) step('1, rnd_data(), 1'b0, 1'b0);
    check("bp_accepts", acc_cnt, FD);
    acc_cnt = 0;
    step('1, rnd_data(), 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step('1, rnd_data(), 1'b0, 1'b0);
    check("bp_one_more", acc_cnt, 1);

    // Full-rate streaming: one accept per cycle in steady state.
    do_reset();
    for (int i = 0; i < 10; i++) step('1, rnd_data(), 1'b1, 1'b0);
    acc_cnt = 0;
    for (int i = 0; i < 20; i++) step('1, rnd_data(), 1'b1, 1'b0);
    check("stream_accepts", acc_cnt, 20);

    // Spurious return with nothing in flight.
    do_reset();
    inj = 1'b1; inj_data = 32'hA5A5_5A5A;
    step('0, rnd_data(), 1'b0, 1'b0);
    inj = 1'b0;
    for (int i = 0; i < 6; i++) step('0, rnd_data(), 1'b1, 1'b0);
    check("err_sticky", err_o, 1);
    do_reset();
    step('0, rnd_data(), 1'b1, 1'b0);

    // Random traffic with occasional mid-run resets.
    for (int i = 0; i < 3000; i++) begin
      logic [NR-1:0] v;
      for (int k = 0; k < NR; k++) v[k] = ($urandom_range(99) < 65);
      step(v, rnd_data(), ($urandom_range(99) < 60), ($urandom_range(299) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
